// File: rtl/mem_port_arbiter_if.sv
// Requester, store-data and memory-side signals of the memory port arbiter.
// The arbiter takes the slave view; the pipeline/memory environment takes the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              if_stall;

    logic              mem_r_en;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              mem_stall;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, ram_rdata,
        output if_rdata, if_ready, if_stall, mem_rdata, mem_ready, mem_stall,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, ram_rdata,
        input  if_rdata, if_ready, if_stall, mem_rdata, mem_ready, mem_stall,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one single-port, fixed-latency
// memory. MEM has priority; arbitration happens only while IDLE.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [3:0] LAT_C = 4'(MEM_LAT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_nx_s;
    logic              owner_d_r;
    logic              owner_d_nx_s;

    logic              ram_en_r;
    logic              ram_en_nx_s;
    logic              ram_we_r;
    logic              ram_we_nx_s;
    logic [ADDR_W-1:0] ram_addr_r;
    logic [ADDR_W-1:0] ram_addr_nx_s;
    logic [DATA_W-1:0] ram_wdata_r;
    logic [DATA_W-1:0] ram_wdata_nx_s;

    logic              if_ready_r;
    logic              if_ready_nx_s;
    logic              mem_ready_r;
    logic              mem_ready_nx_s;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] if_rdata_nx_s;
    logic [DATA_W-1:0] mem_rdata_r;
    logic [DATA_W-1:0] mem_rdata_nx_s;

    logic              mem_req_s;

    // A store wins over a load when both enables are raised together.
    always_comb begin
        mem_req_s = bus.mem_r_en | bus.mem_w_en;
    end

    // Next-state and next-output decode for the IDLE/BUSY/DONE access sequence.
    always_comb begin
        state_nx_s     = state_r;
        cnt_nx_s       = cnt_r;
        owner_d_nx_s   = owner_d_r;
        ram_en_nx_s    = 1'b0;
        ram_we_nx_s    = ram_we_r;
        ram_addr_nx_s  = ram_addr_r;
        ram_wdata_nx_s = ram_wdata_r;
        if_ready_nx_s  = 1'b0;
        mem_ready_nx_s = 1'b0;
        if_rdata_nx_s  = if_rdata_r;
        mem_rdata_nx_s = mem_rdata_r;

        case (state_r)
            ST_IDLE: begin
                if (mem_req_s) begin
                    owner_d_nx_s   = 1'b1;
                    ram_we_nx_s    = bus.mem_w_en;
                    ram_addr_nx_s  = bus.mem_addr;
                    ram_wdata_nx_s = bus.mem_wdata;
                    ram_en_nx_s    = 1'b1;
                    cnt_nx_s       = LAT_C;
                    state_nx_s     = ST_BUSY;
                end else if (bus.if_req) begin
                    owner_d_nx_s   = 1'b0;
                    ram_we_nx_s    = 1'b0;
                    ram_addr_nx_s  = bus.if_addr;
                    ram_wdata_nx_s = {DATA_W{1'b0}};
                    ram_en_nx_s    = 1'b1;
                    cnt_nx_s       = LAT_C;
                    state_nx_s     = ST_BUSY;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end

            ST_BUSY: begin
                cnt_nx_s = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    state_nx_s = ST_DONE;
                    if (owner_d_r) begin
                        mem_ready_nx_s = 1'b1;
                        if (!ram_we_r) begin
                            mem_rdata_nx_s = bus.ram_rdata;
                        end else begin
                            mem_rdata_nx_s = mem_rdata_r;
                        end
                    end else begin
                        if_ready_nx_s = 1'b1;
                        if_rdata_nx_s = bus.ram_rdata;
                    end
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end

            // The ready pulse is visible here; no grant so the requester can retire.
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end

            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = 4'd0;
            end
        endcase
    end

    // State, counter and all registered outputs; reset abandons any access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            owner_d_r   <= 1'b0;
            ram_en_r    <= 1'b0;
            ram_we_r    <= 1'b0;
            ram_addr_r  <= {ADDR_W{1'b0}};
            ram_wdata_r <= {DATA_W{1'b0}};
            if_ready_r  <= 1'b0;
            mem_ready_r <= 1'b0;
            if_rdata_r  <= {DATA_W{1'b0}};
            mem_rdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            owner_d_r   <= owner_d_nx_s;
            ram_en_r    <= ram_en_nx_s;
            ram_we_r    <= ram_we_nx_s;
            ram_addr_r  <= ram_addr_nx_s;
            ram_wdata_r <= ram_wdata_nx_s;
            if_ready_r  <= if_ready_nx_s;
            mem_ready_r <= mem_ready_nx_s;
            if_rdata_r  <= if_rdata_nx_s;
            mem_rdata_r <= mem_rdata_nx_s;
        end
    end

    assign bus.ram_en    = ram_en_r;
    assign bus.ram_we    = ram_we_r;
    assign bus.ram_addr  = ram_addr_r;
    assign bus.ram_wdata = ram_wdata_r;
    assign bus.if_ready  = if_ready_r;
    assign bus.mem_ready = mem_ready_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.mem_rdata = mem_rdata_r;

    // Stalls follow the live request so the pipeline freezes in the request cycle.
    assign bus.if_stall  = bus.if_req & ~if_ready_r;
    assign bus.mem_stall = mem_req_s & ~mem_ready_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: grant table, directed corner
// sequences, then random traffic against a timeline-based reference model.
module tb_mem_port_arbiter;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bit [31:0]   ram_model [1024];
    bit [31:0]   ref_mem   [1024];
    logic        pl_en  = 1'b0;
    logic [9:0]  pl_idx = 10'd0;
    logic [31:0] pl_val = 32'd0;
    int          n_run  = 0;
    int          n_fail = 0;

    assign bus.ram_rdata = ram_model[bus.ram_addr[11:2]];

    // Memory model: backdoor preload or a write on the access strobe.
    always @(posedge clk) begin
        if (pl_en) ram_model[pl_idx] <= pl_val;
        else if (bus.ram_en && bus.ram_we) ram_model[bus.ram_addr[11:2]] <= bus.ram_wdata;
    end

    typedef struct {
        bit          ifr;
        bit          mr;
        bit          mw;
        bit          exp_en;
        bit          exp_we;
        logic [31:0] exp_addr;
        bit          exp_ifs;
        bit          exp_mems;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req = 1'b0; bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] val);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic mem_access(input bit we, input logic [31:0] addr, input logic [31:0] wd);
        int n = 0;
        bus.mem_r_en = ~we; bus.mem_w_en = we; bus.mem_addr = addr; bus.mem_wdata = wd;
        do begin
            tick();
            n++;
        end while (!bus.mem_ready && n < 20);
        chk("mem_access_latency", 32'(n), 32'(LAT + 1));
        bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] rnd_addr();
        return 32'h800 + 32'($urandom_range(0, 511)) * 32'd4;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          g;
        int          free_at;
        bit          o_d;
        bit          a_we;
        logic [31:0] a_addr;
        logic [31:0] a_wd;
        logic [31:0] a_rd;
        logic [31:0] r_if;
        logic [31:0] r_mem;
        bit          e_en;
        bit          e_busy;
        bit          e_ifr;
        bit          e_memr;
        int          sel;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 1'b1};

        // Reset held with both requesters asking.
        bus.if_req = 1'b1; bus.if_addr = 32'h8;
        bus.mem_r_en = 1'b1; bus.mem_w_en = 1'b0; bus.mem_addr = 32'h300; bus.mem_wdata = 32'h0;
        #1;
        repeat (3) tick();
        chk("rst_ram_en", 32'(bus.ram_en), 32'd0);
        chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
        chk("rst_ram_addr", bus.ram_addr, 32'd0);
        chk("rst_ram_wdata", bus.ram_wdata, 32'd0);
        chk("rst_if_ready", 32'(bus.if_ready), 32'd0);
        chk("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        chk("rst_mem_rdata", bus.mem_rdata, 32'd0);
        rst = 1'b1;
        tick();
        chk("rst_first_grant_en", 32'(bus.ram_en), 32'd1);
        chk("rst_first_grant_mem", bus.ram_addr, 32'h300);
        idle_inputs();
        repeat (LAT + 1) tick();

        // Grant table, each vector starting from IDLE.
        bus.if_addr = 32'h100; bus.mem_addr = 32'h200;
        for (int i = 0; i < 8; i++) begin
            bus.if_req = tbl[i].ifr; bus.mem_r_en = tbl[i].mr; bus.mem_w_en = tbl[i].mw;
            bus.mem_wdata = 32'hA5A50000 | 32'(i);
            #1;
            chk($sformatf("tbl%0d_if_stall", i), 32'(bus.if_stall), 32'(tbl[i].exp_ifs));
            chk($sformatf("tbl%0d_mem_stall", i), 32'(bus.mem_stall), 32'(tbl[i].exp_mems));
            tick();
            chk($sformatf("tbl%0d_ram_en", i), 32'(bus.ram_en), 32'(tbl[i].exp_en));
            if (tbl[i].exp_en) begin
                chk($sformatf("tbl%0d_ram_we", i), 32'(bus.ram_we), 32'(tbl[i].exp_we));
                chk($sformatf("tbl%0d_ram_addr", i), bus.ram_addr, tbl[i].exp_addr);
            end
            idle_inputs();
            repeat (LAT + 1) tick();
        end

        // Lone fetch.
        preload(10'd2, 32'hE3A01A01);
        bus.if_req = 1'b1; bus.if_addr = 32'h8;
        #1;
        chk("fetch_c0_stall", 32'(bus.if_stall), 32'd1);
        tick();
        chk("fetch_c1_en", 32'(bus.ram_en), 32'd1);
        chk("fetch_c1_addr", bus.ram_addr, 32'h8);
        chk("fetch_c1_we", 32'(bus.ram_we), 32'd0);
        chk("fetch_c1_stall", 32'(bus.if_stall), 32'd1);
        tick();
        chk("fetch_c2_en", 32'(bus.ram_en), 32'd0);
        chk("fetch_c2_ready", 32'(bus.if_ready), 32'd0);
        chk("fetch_c2_stall", 32'(bus.if_stall), 32'd1);
        tick();
        chk("fetch_c3_ready", 32'(bus.if_ready), 32'd1);
        chk("fetch_c3_rdata", bus.if_rdata, 32'hE3A01A01);
        chk("fetch_c3_stall", 32'(bus.if_stall), 32'd0);
        bus.if_req = 1'b0;
        tick();
        chk("fetch_c4_ready", 32'(bus.if_ready), 32'd0);

        // Contention: store wins, fetch follows in the next IDLE.
        preload(10'd16, 32'h12345678);
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        bus.mem_w_en = 1'b1; bus.mem_addr = 32'd1024; bus.mem_wdata = 32'd8192;
        #1;
        chk("cont_c0_if_stall", 32'(bus.if_stall), 32'd1);
        for (int c = 1; c <= 7; c++) begin
            tick();
            chk($sformatf("cont_c%0d_if_stall", c), 32'(bus.if_stall), (c <= 6) ? 32'd1 : 32'd0);
            chk($sformatf("cont_c%0d_mem_ready", c), 32'(bus.mem_ready), (c == 3) ? 32'd1 : 32'd0);
            chk($sformatf("cont_c%0d_if_ready", c), 32'(bus.if_ready), (c == 7) ? 32'd1 : 32'd0);
            chk($sformatf("cont_c%0d_ram_en", c), 32'(bus.ram_en), (c == 1 || c == 5) ? 32'd1 : 32'd0);
            if (c == 1) begin
                chk("cont_c1_we", 32'(bus.ram_we), 32'd1);
                chk("cont_c1_addr", bus.ram_addr, 32'd1024);
                chk("cont_c1_wdata", bus.ram_wdata, 32'd8192);
            end
            if (c == 3) bus.mem_w_en = 1'b0;
            if (c == 5) begin
                chk("cont_c5_we", 32'(bus.ram_we), 32'd0);
                chk("cont_c5_addr", bus.ram_addr, 32'h40);
            end
            if (c == 7) chk("cont_c7_if_rdata", bus.if_rdata, 32'h12345678);
        end
        bus.if_req = 1'b0;
        tick();

        // Load after store; a store leaves mem_rdata alone.
        mem_access(1'b0, 32'd1024, 32'd0);
        chk("ld_1024", bus.mem_rdata, 32'd8192);
        mem_access(1'b1, 32'd1028, 32'hC0000000);
        chk("st_keeps_mem_rdata", bus.mem_rdata, 32'd8192);
        mem_access(1'b0, 32'd1028, 32'd0);
        chk("ld_1028", bus.mem_rdata, 32'hC0000000);
        chk("ld_if_rdata_kept", bus.if_rdata, 32'h12345678);

        // Fetch flushed during the second BUSY cycle.
        bus.if_req = 1'b1; bus.if_addr = 32'h8;
        tick();
        tick();
        bus.if_req = 1'b0;
        tick();
        chk("flush_c3_ready", 32'(bus.if_ready), 32'd1);
        chk("flush_c3_stall", 32'(bus.if_stall), 32'd0);
        tick();
        chk("flush_c4_ready", 32'(bus.if_ready), 32'd0);
        tick();
        chk("flush_c5_no_grant", 32'(bus.ram_en), 32'd0);
        chk("flush_c5_ready", 32'(bus.if_ready), 32'd0);

        // Reset in the first BUSY cycle, then full restart.
        bus.mem_r_en = 1'b1; bus.mem_addr = 32'd1028;
        tick();
        chk("rbusy_c1_en", 32'(bus.ram_en), 32'd1);
        rst = 1'b0;
        tick();
        chk("rbusy_rst_en", 32'(bus.ram_en), 32'd0);
        chk("rbusy_rst_addr", bus.ram_addr, 32'd0);
        chk("rbusy_rst_ready", 32'(bus.mem_ready), 32'd0);
        chk("rbusy_rst_rdata", bus.mem_rdata, 32'd0);
        rst = 1'b1;
        tick();
        chk("rbusy_r1_en", 32'(bus.ram_en), 32'd1);
        chk("rbusy_r1_addr", bus.ram_addr, 32'd1028);
        tick();
        chk("rbusy_r2_ready", 32'(bus.mem_ready), 32'd0);
        tick();
        chk("rbusy_r3_ready", 32'(bus.mem_ready), 32'd1);
        chk("rbusy_r3_rdata", bus.mem_rdata, 32'hC0000000);
        idle_inputs();
        tick();

        // Random traffic against a timeline model: an access granted at cycle g
        // strobes at g+1, is busy through g+LAT, reports ready at g+LAT+1,
        // and the next grant can come at g+LAT+2 at the earliest.
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        g = -1000; free_at = 0; o_d = 1'b0; a_we = 1'b0;
        a_addr = 32'd0; a_wd = 32'd0; a_rd = 32'd0; r_if = 32'd0; r_mem = 32'd0;
        for (int c = 0; c < 4000; c++) begin
            if (bus.if_req) begin
                if (bus.if_ready) begin
                    if ($urandom_range(0, 1) == 0) bus.if_req = 1'b0;
                    else bus.if_addr = rnd_addr();
                end else if ($urandom_range(0, 19) == 0) begin
                    bus.if_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                bus.if_req = 1'b1; bus.if_addr = rnd_addr();
            end
            if (bus.mem_r_en || bus.mem_w_en) begin
                if (bus.mem_ready) begin
                    bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                sel = int'($urandom_range(1, 3));
                bus.mem_r_en = sel[0]; bus.mem_w_en = sel[1];
                bus.mem_addr = rnd_addr(); bus.mem_wdata = $urandom;
            end
            #1;
            e_en   = (c == g + 1);
            e_busy = (c >= g + 1) && (c <= g + LAT);
            e_ifr  = (c == g + LAT + 1) && !o_d;
            e_memr = (c == g + LAT + 1) && o_d;
            if (e_ifr) r_if = a_rd;
            if (e_memr && !a_we) r_mem = a_rd;
            chk("rnd_ram_en", 32'(bus.ram_en), 32'(e_en));
            chk("rnd_if_ready", 32'(bus.if_ready), 32'(e_ifr));
            chk("rnd_mem_ready", 32'(bus.mem_ready), 32'(e_memr));
            chk("rnd_if_rdata", bus.if_rdata, r_if);
            chk("rnd_mem_rdata", bus.mem_rdata, r_mem);
            chk("rnd_if_stall", 32'(bus.if_stall), 32'(bus.if_req && !e_ifr));
            chk("rnd_mem_stall", 32'(bus.mem_stall), 32'((bus.mem_r_en || bus.mem_w_en) && !e_memr));
            if (e_busy) begin
                chk("rnd_ram_we", 32'(bus.ram_we), 32'(a_we));
                chk("rnd_ram_addr", bus.ram_addr, a_addr);
                if (a_we) chk("rnd_ram_wdata", bus.ram_wdata, a_wd);
            end
            if (c >= free_at && (bus.mem_r_en || bus.mem_w_en || bus.if_req)) begin
                g = c;
                free_at = c + LAT + 2;
                o_d = bus.mem_r_en || bus.mem_w_en;
                a_we = o_d && bus.mem_w_en;
                a_addr = o_d ? bus.mem_addr : bus.if_addr;
                a_wd = bus.mem_wdata;
                if (a_we) ref_mem[a_addr[11:2]] = a_wd;
                else a_rd = ref_mem[a_addr[11:2]];
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency memory between two requesters: the instruction-fetch stage (IF) and the data-access stage (MEM) of the 5-stage ARM-subset pipeline.
- Sits between the IF/MEM stages and the unified memory.
- Serialises accesses and gives MEM priority over IF.
- Emits stall signals that the hazard/freeze logic uses to hold the pipeline.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data word width.
- MEM_LAT, 2, number of cycles the memory is busy per access (legal range 1..15).

Ports:
- clk  in  1  system clock; everything is sampled on its rising edge.
- rst  in  1  synchronous, active-low reset.
- if_req  in  1  IF fetch request; level, held until if_ready.
- if_addr  in  ADDR_W  fetch address (PC).
- if_rdata  out  DATA_W  fetched instruction.
- if_ready  out  1  one-cycle pulse: the fetch is complete and if_rdata is valid.
- if_stall  out  1  IF must freeze.
- mem_r_en  in  1  MEM-stage load request; level.
- mem_w_en  in  1  MEM-stage store request; level.
- mem_addr  in  ADDR_W  load/store address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load result.
- mem_ready  out  1  one-cycle pulse: the load/store is complete.
- mem_stall  out  1  the pipeline must freeze for the MEM access.
- ram_en  out  1  one-cycle access strobe to the memory.
- ram_we  out  1  write enable; held for the whole access.
- ram_addr  out  ADDR_W  access address; held for the whole access.
- ram_wdata  out  DATA_W  write data; held for the whole access.
- ram_rdata  in  DATA_W  memory read data; valid at the end of the last busy cycle.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE, counter=0.
  - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - if_ready=0, mem_ready=0, if_rdata=0, mem_rdata=0.
  - Any in-flight access is abandoned; there is no retry and no ready pulse.
- FSM states: IDLE, BUSY, DONE. All ram_* outputs, ready outputs and rdata outputs are registered.
- IDLE:
  - If mem_r_en or mem_w_en is high, grant MEM (owner=D).
  - Otherwise, if if_req is high, grant IF (owner=I).
  - Otherwise stay in IDLE.
  - On a grant:
    - Latch the address, wdata and we (we = mem_w_en for D, 0 for I).
    - Next cycle: ram_en=1, counter=MEM_LAT, state=BUSY.
  - With both mem_r_en and mem_w_en high, the access is a write (ram_we=1).
- BUSY:
  - ram_en is high only in the first BUSY cycle.
  - ram_we, ram_addr and ram_wdata stay stable for all MEM_LAT BUSY cycles.
  - counter decrements every cycle.
  - In the cycle with counter==1:
    - At the edge, capture ram_rdata into if_rdata (owner I) or mem_rdata (owner D, read only).
    - Set the owner's ready to 1 and go to DONE.
- DONE:
  - The owner's ready is high for exactly this cycle; state goes to IDLE.
  - No grant is made in DONE, so the requester can drop or replace its request.
- Latency: request seen in IDLE at cycle 0 → BUSY in cycles 1..MEM_LAT → ready in cycle MEM_LAT+1. Back-to-back throughput is one access per MEM_LAT+2 cycles.
- Writes: mem_ready pulses and mem_rdata keeps its previous value.
- Data outputs: if_rdata and mem_rdata hold their value until overwritten by a later access of the same type.
- Stalls (combinational):
  - if_stall = if_req & ~if_ready.
  - mem_stall = (mem_r_en | mem_w_en) & ~mem_ready.
- Request dropped mid-access (e.g. IF flushed by a taken branch): the access still completes and the ready pulse still occurs; the requester ignores it. No cancellation.
- Simultaneous IF and MEM requests in IDLE: MEM wins. IF is served at the next IDLE in which no MEM request is pending. IF starvation is bounded because the frozen pipeline creates no new MEM request until the current one retires.
- Request raised while BUSY/DONE: wait; arbitration happens only in IDLE.
- Only one ready pulse per access, and if_ready and mem_ready are never high together.

Test Plan:
- Reset: hold rst=0 for 3 cycles with both requests high → all outputs 0, state IDLE; release → MEM is granted first.
- Lone fetch, MEM_LAT=2: if_req=1, if_addr=0x8, ram_rdata=0xE3A01A01 → ram_en pulses in cycle 1 with ram_addr=0x8, ram_we=0; if_ready=1 in cycle 3 with if_rdata=0xE3A01A01; if_stall high in cycles 0..2.
- Contention: in cycle 0, if_req=1 (addr 0x40) and mem_w_en=1 (addr 1024, wdata 8192):
  - Expect: ram_we=1, addr 1024 first; mem_ready in cycle 3.
  - Then the IF grant in cycle 4 (IDLE); if_ready in cycle 7.
  - Expect: if_stall high throughout cycles 0..6.
- Load after store: store 0xC0000000 to 1028, then mem_r_en at 1028 with the memory model returning the stored value → mem_rdata=0xC0000000; if_rdata unchanged.
- Flush mid-access: if_req drops during the second BUSY cycle → if_ready still pulses once; the next IDLE makes no grant.
- Reset mid-BUSY: rst=0 in BUSY cycle 1 → no ready pulse, ram_en=0; after release, the pending request restarts from IDLE with the full latency.
